// File: rtl/truth_table_capture.sv
// Sweeps every input combination through a function under test and captures its truth table; valid 2^N*SETTLE_CYCLES cycles after start.
// Word is held on tt_out/tt_valid until tt_ready; abort cancels a sweep or a pending word at the next edge.
module truth_table_capture #(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic [N_INPUTS-1:0]      drive,
    input  logic                     sample_in,
    output logic [(1<<N_INPUTS)-1:0] tt_out,
    output logic                     tt_valid,
    input  logic                     tt_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_VALID  = 2'd2;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] DRIVE_LAST = '1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            drive    <= '0;
            cnt      <= '0;
            tt_out   <= '0;
            busy     <= 1'b0;
            tt_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    drive <= '0;
                    cnt   <= '0;
                    // abort beats start so a held abort keeps the block parked
                    if (start && !abort) begin
                        state  <= S_SETTLE;
                        busy   <= 1'b1;
                        tt_out <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        drive    <= '0;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        tt_valid <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        tt_out[drive] <= sample_in;
                        cnt           <= '0;
                        if (drive == DRIVE_LAST) begin
                            state    <= S_VALID;
                            tt_valid <= 1'b1;
                            drive    <= '0;
                        end else begin
                            drive <= drive + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_VALID: begin
                    drive <= '0;
                    cnt   <= '0;
                    if (abort || tt_ready) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        tt_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    drive    <= '0;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    tt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
